// File: rtl/cmd_bus_master.sv
// Byte-stream command decoder driving a basil-style split register bus (burst write/read).
// Define CMD_BUS_MASTER_TIMEOUT_EN to abort commands that stall mid-stream for TIMEOUT cycles.
module cmd_bus_master #(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] BUS_ADD,
    output logic [7:0]  BUS_DATA_OUT,
    input  logic [7:0]  BUS_DATA_IN,
    output logic        BUS_RD,
    output logic        BUS_WR,
    output logic        BUSY,
    output logic        ERROR
);

    typedef enum logic [2:0] {
        StIdle, StAddrH, StAddrL, StLen, StWrData, StRdIssue, StRdWait
    } state_t;

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t      state;
    logic [15:0] addr;
    logic [8:0]  remaining;
    logic        is_read;
    logic [2:0]  lat_cnt;
    logic        accept;
    logic        timed_phase;
    logic        timed_out;

    assign IN_READY    = state inside {StIdle, StAddrH, StAddrL, StLen, StWrData};
    assign accept      = IN_VALID & IN_READY;
    assign BUSY        = (state != StIdle);
    assign timed_phase = state inside {StAddrH, StAddrL, StLen, StWrData};

`ifdef CMD_BUS_MASTER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    logic [31:0] idle_cnt;

    assign timed_out = timed_phase && !IN_VALID && (idle_cnt == TO_LAST);

    always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
        if (!BUS_RST) begin
            idle_cnt <= '0;
        end else if (!timed_phase || accept || timed_out) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = timed_phase | (TIMEOUT == 0);
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
        if (!BUS_RST) begin
            state        <= StIdle;
            addr         <= '0;
            remaining    <= '0;
            is_read      <= 1'b0;
            lat_cnt      <= '0;
            BUS_ADD      <= '0;
            BUS_DATA_OUT <= '0;
            BUS_RD       <= 1'b0;
            BUS_WR       <= 1'b0;
            OUT_DATA     <= '0;
            OUT_VALID    <= 1'b0;
            ERROR        <= 1'b0;
        end else begin
            BUS_RD       <= 1'b0;
            BUS_WR       <= 1'b0;
            BUS_DATA_OUT <= '0;
            ERROR        <= 1'b0;
            if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
            if (timed_out) begin
                ERROR <= 1'b1;
                state <= StIdle;
            end else begin
                unique case (state)
                    StIdle: if (accept) begin
                        if (IN_DATA[6:0] != 7'd0) begin
                            ERROR <= 1'b1;
                        end else begin
                            is_read <= IN_DATA[7];
                            state   <= StAddrH;
                        end
                    end
                    StAddrH: if (accept) begin
                        addr[15:8] <= IN_DATA;
                        state      <= StAddrL;
                    end
                    StAddrL: if (accept) begin
                        addr[7:0] <= IN_DATA;
                        state     <= StLen;
                    end
                    StLen: if (accept) begin
                        // LEN of zero encodes a full 256-byte burst
                        remaining <= {IN_DATA == 8'd0, IN_DATA};
                        state     <= is_read ? StRdIssue : StWrData;
                    end
                    StWrData: if (accept) begin
                        BUS_WR       <= 1'b1;
                        BUS_ADD      <= addr;
                        BUS_DATA_OUT <= IN_DATA;
                        addr         <= addr + 16'd1;
                        remaining    <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            state <= StIdle;
                        end
                    end
                    StRdIssue: if (!OUT_VALID) begin
                        // Only one read in flight: wait until the previous byte is consumed
                        BUS_RD  <= 1'b1;
                        BUS_ADD <= addr;
                        lat_cnt <= '0;
                        state   <= StRdWait;
                    end
                    StRdWait: begin
                        if (lat_cnt == LAT) begin
                            OUT_DATA  <= BUS_DATA_IN;
                            OUT_VALID <= 1'b1;
                            addr      <= addr + 16'd1;
                            remaining <= remaining - 9'd1;
                            state     <= (remaining == 9'd1) ? StIdle : StRdIssue;
                        end else begin
                            lat_cnt <= lat_cnt + 3'd1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/cmd_bus_master.md
# cmd_bus_master

Byte-stream-to-bus initiator. It drives the split basil-style register bus (BUS_ADD, BUS_DATA_OUT, BUS_DATA_IN, BUS_RD, BUS_WR) from a command byte stream, for example behind a UART or FIFO bridge. Each command is a burst of single-byte writes or reads with auto-incrementing address. Read data is returned on an output byte stream with valid/ready handshake.

## Interface
- RD_LATENCY, 1: cycles from BUS_RD pulse to valid BUS_DATA_IN (1..4)
- TIMEOUT, 1000: idle input cycles tolerated mid-command (only with CMD_BUS_MASTER_TIMEOUT_EN)
- BUS_CLK  in  1  clock, all logic rising-edge
- BUS_RST  in  1  reset; one clock; reset is asynchronous and active-low
- IN_DATA  in  8  command/data byte
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  byte accepted when IN_VALID & IN_READY
- OUT_DATA  out  8  read-back byte
- OUT_VALID  out  1  OUT_DATA valid
- OUT_READY  in  1  consumer accepts when OUT_VALID & OUT_READY
- BUS_ADD  out  16  bus address
- BUS_DATA_OUT  out  8  write data
- BUS_DATA_IN  in  8  read data from peripherals
- BUS_RD  out  1  one-cycle read strobe
- BUS_WR  out  1  one-cycle write strobe
- BUSY  out  1  high in any state except IDLE
- ERROR  out  1  one-cycle pulse on protocol error

## Operation
- Command format: HDR, ADDR_H, ADDR_L, LEN, then LEN data bytes for writes only.
- HDR bit7 selects the direction: 1 = read, 0 = write. HDR bits[6:0] must be 0.
- LEN = 0 means 256 bytes.
- States: IDLE → ADDR_H → ADDR_L → LEN → WR_DATA | RD_ISSUE ⇄ RD_WAIT → IDLE.
- IDLE: IN_READY=1. A HDR with nonzero bits[6:0] is discarded, ERROR pulses, and the block stays in IDLE.
- ADDR_H, ADDR_L, LEN: IN_READY=1. Each accepted byte advances the state.
- WR_DATA: IN_READY=1. Each accepted byte produces one write transaction, then the address increments.
- WR_DATA exits to IDLE after the LEN-th byte.
- RD_ISSUE: IN_READY=0.
  - BUS_RD is issued only when OUT_VALID=0, so at most one read is outstanding.
  - Then go to RD_WAIT.
- RD_WAIT: wait RD_LATENCY cycles and capture BUS_DATA_IN into OUT_DATA.
  - Decrement the remaining count and increment the address.
  - Return to RD_ISSUE, or to IDLE after the last byte.
- Address arithmetic is 16-bit and wraps 0xFFFF → 0x0000 within a burst.
- The remaining-count register is 9 bits wide.
- OUT_VALID stays high until OUT_READY. An OUT_READY asserted while OUT_VALID=0 is ignored.
- Reset mid-command: all state is discarded, and the bus strobes are low from reset assertion onward.

## Timing
- Reset values:
  - BUS_ADD=0, BUS_DATA_OUT=0, BUS_RD=0, BUS_WR=0
  - OUT_DATA=0, OUT_VALID=0
  - BUSY=0, ERROR=0
  - IN_READY=1, state IDLE
- Write: a byte accepted at edge N causes BUS_WR=1, BUS_ADD=addr and BUS_DATA_OUT=byte during cycle N+1.
  - BUS_DATA_OUT returns to 0 when BUS_WR=0.
  - Back-to-back bytes give back-to-back write cycles.
- Read: BUS_RD=1 in cycle T with BUS_ADD valid.
  - BUS_DATA_IN is sampled at the edge ending cycle T+RD_LATENCY.
  - OUT_VALID=1 from cycle T+RD_LATENCY+1.
  - Next BUS_RD no earlier than the cycle after OUT_VALID falls.
- BUS_RD and BUS_WR are never high together. Each is exactly one cycle wide per transaction.
- BUS_ADD holds its last value when no strobe is active.
- ERROR is a single-cycle registered pulse.

## Configuration
- CMD_BUS_MASTER_TIMEOUT_EN defined:
  - In ADDR_H, ADDR_L, LEN and WR_DATA, a counter counts consecutive cycles with IN_VALID=0 and clears on each accepted byte.
  - At TIMEOUT the block pulses ERROR and returns to IDLE. Writes already issued remain committed.
  - Read phases are never timed out.
- Undefined: no counter. A stalled command waits forever. ERROR fires only on a bad HDR.

## Test plan
- Bench bus responder: a 64 KiB byte memory with RD_LATENCY=1.
- Write burst: stream 00 00 00 02 AA 55.
  - Expect WR at 0x0000 with AA, then WR at 0x0001 with 55, on consecutive cycles.
  - Then BUSY=0.
- Read with back-pressure: preload 0x0010=A5 and 0x0011=CD. Stream 80 00 10 02, with OUT_READY held low 5 cycles.
  - OUT_DATA=A5 holds valid through the stall.
  - Exactly one BUS_RD before the stall releases.
  - Then CD is returned.
- Wrap: stream 00 FF FF 02 11 22.
  - Expect writes at 0xFFFF=11 and 0x0000=22.
- Bad header: stream 41.
  - ERROR pulses once, no bus strobe, state IDLE.
  - A following valid command executes normally.
- LEN=0: stream 80 01 00 00.
  - Exactly 256 reads at 0x0100..0x01FF, then IDLE.
- Timeout (macro defined, TIMEOUT=16): stream 00 00 20, then idle 16 cycles.
  - ERROR pulses, no BUS_WR.
  - The next byte 00 is taken as a new HDR.
